// File: rtl/access_req_arbiter.sv
// Front end of the MPU access checker: one request slot per core, round-robin
// issue of one check at a time, per-core response pulses and violation reporting.
module access_req_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int TIMEOUT       = 16,
  parameter int VCNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            req_valid,
  output logic [NUM_CORES-1:0]            req_ready,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CORES-1:0]            req_we,
  output logic [NUM_CORES-1:0]            rsp_valid,
  output logic                            rsp_granted,
  output logic                            rsp_timeout,
  output logic                            chk_cs,
  output logic [CORE_ID_WIDTH-1:0]        chk_core_id,
  output logic [ADDR_WIDTH-1:0]           chk_addr,
  output logic                            chk_we,
  input  logic                            chk_result,
  input  logic                            chk_bsy,
  output logic                            viol_valid,
  output logic [CORE_ID_WIDTH-1:0]        viol_core,
  output logic [ADDR_WIDTH-1:0]           viol_addr,
  output logic                            viol_we,
  output logic [VCNT_WIDTH-1:0]           viol_count,
  output logic                            o_dbg_state
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  // Request slots
  logic [NUM_CORES-1:0]   r_pending;
  logic [ADDR_WIDTH-1:0]  r_slot_addr [NUM_CORES];
  logic [NUM_CORES-1:0]   r_slot_we;

  // Arbitration / check tracking
  logic [CORE_ID_WIDTH-1:0] r_rr_ptr;
  logic [CORE_ID_WIDTH-1:0] r_sel;
  logic [TIMER_W-1:0]       r_timer;
  logic                     r_seen_bsy;
  logic                     r_chk_cs;
  logic [ADDR_WIDTH-1:0]    r_chk_addr;
  logic                     r_chk_we;

  // Response / violation registers
  logic [NUM_CORES-1:0]     r_rsp_valid;
  logic                     r_rsp_granted;
  logic                     r_rsp_timeout;
  logic                     r_viol_valid;
  logic [CORE_ID_WIDTH-1:0] r_viol_core;
  logic [ADDR_WIDTH-1:0]    r_viol_addr;
  logic                     r_viol_we;
  logic [VCNT_WIDTH-1:0]    r_viol_count;

  logic [NUM_CORES-1:0]     w_capture;
  logic [NUM_CORES-1:0]     w_release;
  logic [CORE_ID_WIDTH-1:0] w_pick;
  logic                     w_pick_found;
  logic                     w_issue;
  logic                     w_respond;
  logic                     w_granted;
  logic                     w_timeout_hit;

  // Index arithmetic modulo NUM_CORES; step is always below NUM_CORES.
  function automatic logic [CORE_ID_WIDTH-1:0] wrap_add(
    input logic [CORE_ID_WIDTH-1:0] idx,
    input int                       step
  );
    int v_sum;
    v_sum = int'(idx) + step;
    if (v_sum >= NUM_CORES) begin
      v_sum = v_sum - NUM_CORES;
    end
    return CORE_ID_WIDTH'(v_sum);
  endfunction

  // Handshake: a core's request is taken on any cycle where req_valid[i] and
  // req_ready[i] are both high; ready drops while the slot holds a request and
  // rises again in the cycle that slot's rsp_valid pulse is presented.
  assign req_ready = ~r_pending;
  assign w_capture = req_valid & ~r_pending;
  assign w_release = w_respond ? (NUM_CORES'(1) << r_sel) : '0;

  // First pending core at or after the round-robin pointer.
  always_comb begin
    w_pick       = r_rr_ptr;
    w_pick_found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_pick_found && r_pending[wrap_add(r_rr_ptr, k)]) begin
        w_pick       = wrap_add(r_rr_ptr, k);
        w_pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_respond     = 1'b0;
    w_granted     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // A checker still busy from an abandoned check blocks the next issue.
        if (w_pick_found && !chk_bsy) begin
          w_issue     = 1'b1;
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (r_seen_bsy && !chk_bsy) begin
          w_respond   = 1'b1;
          w_granted   = chk_result;
          w_state_nxt = ARB_IDLE;
        end else if (r_timer == TIMER_LAST) begin
          w_respond     = 1'b1;
          w_timeout_hit = 1'b1;
          w_state_nxt   = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_release) | w_capture;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_slot_addr[i] <= '0;
      end
      r_slot_we <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_capture[i]) begin
          r_slot_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_slot_we[i]   <= req_we[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_timer    <= '0;
      r_seen_bsy <= 1'b0;
      r_chk_cs   <= 1'b0;
      r_chk_addr <= '0;
      r_chk_we   <= 1'b0;
    end else begin
      r_chk_cs <= w_issue;
      if (w_issue) begin
        r_sel      <= w_pick;
        r_rr_ptr   <= wrap_add(w_pick, 1);
        r_chk_addr <= r_slot_addr[w_pick];
        r_chk_we   <= r_slot_we[w_pick];
        r_timer    <= '0;
        r_seen_bsy <= 1'b0;
      end else if (r_state == ARB_WAIT) begin
        r_timer <= r_timer + TIMER_W'(1);
        if (chk_bsy) begin
          r_seen_bsy <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= '0;
      r_rsp_granted <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_viol_valid  <= 1'b0;
      r_viol_core   <= '0;
      r_viol_addr   <= '0;
      r_viol_we     <= 1'b0;
      r_viol_count  <= '0;
    end else begin
      r_rsp_valid  <= w_release;
      r_viol_valid <= w_respond && !w_granted;
      if (w_respond) begin
        r_rsp_granted <= w_granted;
        r_rsp_timeout <= w_timeout_hit;
        if (!w_granted) begin
          r_viol_core <= r_sel;
          r_viol_addr <= r_slot_addr[r_sel];
          r_viol_we   <= r_slot_we[r_sel];
          if (r_viol_count != {VCNT_WIDTH{1'b1}}) begin
            r_viol_count <= r_viol_count + VCNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_granted = r_rsp_granted;
  assign rsp_timeout = r_rsp_timeout;
  assign chk_cs      = r_chk_cs;
  assign chk_core_id = r_sel;
  assign chk_addr    = r_chk_addr;
  assign chk_we      = r_chk_we;
  assign viol_valid  = r_viol_valid;
  assign viol_core   = r_viol_core;
  assign viol_addr   = r_viol_addr;
  assign viol_we     = r_viol_we;
  assign viol_count  = r_viol_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_access_req_arbiter.sv
// Bench for access_req_arbiter: transaction-level model of the slot/round-robin
// rules, an emulated checker, directed scenarios and randomized traffic.
module tb_access_req_arbiter;
  localparam int N   = 4;
  localparam int CIW = 2;
  localparam int AW  = 32;
  localparam int TMO = 16;
  localparam int VW  = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    rsp_valid;
  logic            rsp_granted, rsp_timeout;
  logic            chk_cs;
  logic [CIW-1:0]  chk_core_id;
  logic [AW-1:0]   chk_addr;
  logic            chk_we;
  logic            chk_result = 1'b0;
  logic            chk_bsy = 1'b0;
  logic            viol_valid;
  logic [CIW-1:0]  viol_core;
  logic [AW-1:0]   viol_addr;
  logic            viol_we;
  logic [VW-1:0]   viol_count;
  logic            dbg_state;

  // Second instance with a 2-bit violation counter, same stimulus.
  logic [N-1:0]    req_ready_s, rsp_valid_s;
  logic            rsp_granted_s, rsp_timeout_s, chk_cs_s, chk_we_s;
  logic [CIW-1:0]  chk_core_id_s, viol_core_s;
  logic [AW-1:0]   chk_addr_s, viol_addr_s;
  logic            viol_valid_s, viol_we_s, dbg_state_s;
  logic [1:0]      viol_count_s;

  access_req_arbiter #(.NUM_CORES(N), .CORE_ID_WIDTH(CIW), .ADDR_WIDTH(AW),
                       .TIMEOUT(TMO), .VCNT_WIDTH(VW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .rsp_valid(rsp_valid),
    .rsp_granted(rsp_granted), .rsp_timeout(rsp_timeout), .chk_cs(chk_cs),
    .chk_core_id(chk_core_id), .chk_addr(chk_addr), .chk_we(chk_we),
    .chk_result(chk_result), .chk_bsy(chk_bsy), .viol_valid(viol_valid),
    .viol_core(viol_core), .viol_addr(viol_addr), .viol_we(viol_we),
    .viol_count(viol_count), .o_dbg_state(dbg_state)
  );

  access_req_arbiter #(.NUM_CORES(N), .CORE_ID_WIDTH(CIW), .ADDR_WIDTH(AW),
                       .TIMEOUT(TMO), .VCNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_addr(req_addr), .req_we(req_we), .rsp_valid(rsp_valid_s),
    .rsp_granted(rsp_granted_s), .rsp_timeout(rsp_timeout_s), .chk_cs(chk_cs_s),
    .chk_core_id(chk_core_id_s), .chk_addr(chk_addr_s), .chk_we(chk_we_s),
    .chk_result(chk_result), .chk_bsy(chk_bsy), .viol_valid(viol_valid_s),
    .viol_core(viol_core_s), .viol_addr(viol_addr_s), .viol_we(viol_we_s),
    .viol_count(viol_count_s), .o_dbg_state(dbg_state_s)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  bit [N-1:0]    m_pend;
  logic [AW-1:0] m_addr [N];
  bit            m_we [N];
  int            m_rr, m_cur, m_elapsed, m_viol_total;
  bit            m_active, m_seen;
  bit            e_cs, e_cwe, e_granted, e_timeout, e_viol_valid, e_vwe;
  int            e_core, e_vcore;
  logic [AW-1:0] e_caddr, e_vaddr;
  bit [N-1:0]    e_rsp_valid;
  logic [CIW-1:0] exp_q[$];

  // Checker emulator
  bit ch_on;
  int ch_t, ch_l;
  bit rand_mode = 1'b0;
  int dir_l = 3;
  bit dir_res = 1'b1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_pend = '0; m_rr = 0; m_cur = 0; m_elapsed = 0; m_viol_total = 0;
    m_active = 0; m_seen = 0;
    for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_we[i] = 0; end
    e_cs = 0; e_cwe = 0; e_granted = 0; e_timeout = 0; e_viol_valid = 0; e_vwe = 0;
    e_core = 0; e_vcore = 0; e_caddr = '0; e_vaddr = '0; e_rsp_valid = '0;
    exp_q.delete();
    ch_on = 0; ch_t = 0; ch_l = 0;
    chk_bsy = 1'b0; chk_result = 1'b0;
  endtask

  // What the next clock edge must do, given current inputs and model state.
  task automatic model_edge();
    bit [N-1:0] cap;
    bit done;
    int pick;
    cap = req_valid & ~m_pend;
    e_cs = 0; e_rsp_valid = '0; e_viol_valid = 0;
    if (!m_active) begin
      if (m_pend != 0 && !chk_bsy) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
        end
        m_active = 1; m_cur = pick; m_elapsed = 0; m_seen = 0;
        m_rr = (pick + 1) % N;
        e_cs = 1; e_core = pick; e_caddr = m_addr[pick]; e_cwe = m_we[pick];
        exp_q.push_back(CIW'(pick));
      end
    end else begin
      m_elapsed++;
      done = m_seen && !chk_bsy;
      if (done || m_elapsed >= TMO) begin
        e_rsp_valid[m_cur] = 1'b1;
        e_granted = done ? chk_result : 1'b0;
        e_timeout = !done;
        if (!e_granted) begin
          e_viol_valid = 1; e_vcore = m_cur; e_vaddr = m_addr[m_cur]; e_vwe = m_we[m_cur];
          m_viol_total++;
        end
        m_pend[m_cur] = 0;
        m_active = 0;
      end else if (chk_bsy) begin
        m_seen = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cap[i]) begin
        m_pend[i] = 1; m_addr[i] = req_addr[i*AW +: AW]; m_we[i] = req_we[i];
      end
    end
  endtask

  task automatic compare_all();
    bit [N-1:0] exp_ready;
    int vc16, vc2;
    exp_ready = ~m_pend;
    vc16 = (m_viol_total > 65535) ? 65535 : m_viol_total;
    vc2  = (m_viol_total > 3) ? 3 : m_viol_total;
    cmp("req_ready", 64'(req_ready), 64'(exp_ready));
    cmp("chk_cs", 64'(chk_cs), 64'(e_cs));
    cmp("chk_core_id", 64'(chk_core_id), 64'(e_core));
    cmp("chk_addr", 64'(chk_addr), 64'(e_caddr));
    cmp("chk_we", 64'(chk_we), 64'(e_cwe));
    cmp("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    cmp("rsp_granted", 64'(rsp_granted), 64'(e_granted));
    cmp("rsp_timeout", 64'(rsp_timeout), 64'(e_timeout));
    cmp("viol_valid", 64'(viol_valid), 64'(e_viol_valid));
    cmp("viol_core", 64'(viol_core), 64'(e_vcore));
    cmp("viol_addr", 64'(viol_addr), 64'(e_vaddr));
    cmp("viol_we", 64'(viol_we), 64'(e_vwe));
    cmp("viol_count", 64'(viol_count), 64'(vc16));
    cmp("viol_count_sat", 64'(viol_count_s), 64'(vc2));
    cmp("dbg_state", 64'(dbg_state), 64'(m_active));
    if (chk_cs === 1'b1) begin
      if (exp_q.size() == 0) fail_bound("issue_order_unexpected");
      else cmp("issue_order", 64'(chk_core_id), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic emu_update();
    if (e_cs) begin
      ch_on = 1; ch_t = 0;
      if (rand_mode) begin
        ch_l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 24)) : int'($urandom_range(0, 5));
        chk_result = 1'($urandom_range(0, 1));
      end else begin
        ch_l = dir_l;
        chk_result = dir_res;
      end
    end else if (ch_on) begin
      ch_t++;
      if (ch_t > ch_l) ch_on = 0;
    end
    chk_bsy = ch_on && (ch_t >= 1) && (ch_t <= ch_l);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    emu_update();
  endtask

  task automatic set_req(input int core, input logic [AW-1:0] addr, input bit we);
    req_valid[core] = 1'b1;
    req_addr[core*AW +: AW] = addr;
    req_we[core] = we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_req_ready", 64'(req_ready), 64'(4'hF));
    cmp("rst_chk_cs", 64'(chk_cs), 64'(0));
    cmp("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    cmp("rst_viol_valid", 64'(viol_valid), 64'(0));
    cmp("rst_viol_count", 64'(viol_count), 64'(0));
    cmp("rst_chk_addr", 64'(chk_addr), 64'(0));
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int max_steps, output int steps, output bit ok);
    ok = 0;
    steps = 0;
    while (!ok && steps < max_steps) begin
      step();
      steps++;
      if (|rsp_valid === 1'b1) ok = 1;
    end
    if (!ok) fail_bound("wait_rsp");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tcs, trsp, cs_busy, cs_tot, rsp_seen;
    bit ok, got, rereq, clr_next, b;
    int obs_q[$];
    int exp_rr[5];
    int exp_sat[5];

    do_reset();

    // Single granted read from core 1
    dir_l = 3; dir_res = 1;
    set_req(1, 32'h0000_1000, 1'b0);
    step();
    req_valid = '0;
    wait_rsp(20, n, ok);
    if (ok) begin
      cmp("read_latency", 64'(n), 64'(6));
      cmp("read_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      cmp("read_granted", 64'(rsp_granted), 64'(1));
      cmp("read_no_viol", 64'(viol_valid), 64'(0));
      cmp("read_ready1", 64'(req_ready[1]), 64'(1));
    end

    // Denied write from core 2
    dir_res = 0;
    set_req(2, 32'h0000_2000, 1'b1);
    step();
    req_valid = '0;
    wait_rsp(20, n, ok);
    if (ok) begin
      cmp("deny_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
      cmp("deny_granted", 64'(rsp_granted), 64'(0));
      cmp("deny_viol_valid", 64'(viol_valid), 64'(1));
      cmp("deny_viol_core", 64'(viol_core), 64'(2));
      cmp("deny_viol_addr", 64'(viol_addr), 64'(32'h0000_2000));
      cmp("deny_viol_we", 64'(viol_we), 64'(1));
      cmp("deny_viol_count", 64'(viol_count), 64'(1));
    end

    // Round-robin from reset, core 0 re-requests after its own response
    do_reset();
    dir_l = 3; dir_res = 1;
    for (int i = 0; i < N; i++) set_req(i, 32'h3000 + 32'(i * 16), 1'(i));
    step();
    req_valid = '0;
    rereq = 0; clr_next = 0;
    for (int s = 0; s < 200 && !(obs_q.size() >= 5 && m_pend == 0 && !m_active); s++) begin
      step();
      if (clr_next) begin req_valid = '0; clr_next = 0; end
      if (chk_cs === 1'b1) obs_q.push_back(int'(chk_core_id));
      if (!rereq && rsp_valid === 4'b0001) begin
        set_req(0, 32'h0000_3100, 1'b1);
        rereq = 1; clr_next = 1;
      end
    end
    exp_rr = '{0, 1, 2, 3, 0};
    cmp("rr_issue_count", 64'(obs_q.size()), 64'(5));
    for (int i = 0; i < 5 && i < obs_q.size(); i++) cmp("rr_order", 64'(obs_q[i]), 64'(exp_rr[i]));

    // Timeout: checker stays busy well past the limit
    dir_l = 40; dir_res = 1;
    set_req(3, 32'h0000_4000, 1'b0);
    step();
    req_valid = '0;
    tcs = -1; trsp = -1; got = 0;
    for (int s = 0; s < 40 && !got; s++) begin
      step();
      if (chk_cs === 1'b1 && tcs < 0) tcs = cyc;
      if (|rsp_valid === 1'b1) begin got = 1; trsp = cyc; end
    end
    if (!got || tcs < 0) fail_bound("timeout_rsp");
    else begin
      cmp("timeout_cycles", 64'(trsp - tcs), 64'(16));
      cmp("timeout_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
      cmp("timeout_flag", 64'(rsp_timeout), 64'(1));
      cmp("timeout_granted", 64'(rsp_granted), 64'(0));
      cmp("timeout_viol", 64'(viol_valid), 64'(1));
    end
    dir_l = 3; dir_res = 1;
    set_req(1, 32'h0000_4100, 1'b1);
    b = chk_bsy;
    step();
    req_valid = '0;
    cs_busy = 0; cs_tot = 0; got = 0;
    if (chk_cs === 1'b1) begin cs_tot++; if (b) cs_busy++; end
    for (int s = 0; s < 60 && !got; s++) begin
      b = chk_bsy;
      step();
      if (chk_cs === 1'b1) begin cs_tot++; if (b) cs_busy++; end
      if (|rsp_valid === 1'b1) got = 1;
    end
    if (!got) fail_bound("after_timeout_rsp");
    cmp("cs_while_busy", 64'(cs_busy), 64'(0));
    cmp("cs_after_busy", 64'(cs_tot), 64'(1));
    cmp("after_timeout_rsp", 64'(rsp_valid), 64'(4'b0010));

    // Reset while a check is in flight with three slots pending
    dir_l = 3; dir_res = 1;
    set_req(0, 32'h0000_5000, 1'b0);
    set_req(1, 32'h0000_5010, 1'b1);
    set_req(2, 32'h0000_5020, 1'b0);
    step();
    req_valid = '0;
    got = 0;
    for (int s = 0; s < 10 && !got; s++) begin
      step();
      if (e_cs) got = 1;
    end
    if (!got) fail_bound("midreset_issue");
    #1 rst_n = 1'b0;
    #1;
    cmp("midreset_ready", 64'(req_ready), 64'(4'hF));
    cmp("midreset_chk_cs", 64'(chk_cs), 64'(0));
    cmp("midreset_rsp", 64'(rsp_valid), 64'(0));
    model_reset();
    #2 rst_n = 1'b1;
    rsp_seen = 0;
    repeat (30) begin
      step();
      if (|rsp_valid === 1'b1) rsp_seen++;
    end
    cmp("midreset_no_rsp", 64'(rsp_seen), 64'(0));

    // Saturating 2-bit counter over five denials
    exp_sat = '{1, 2, 3, 3, 3};
    dir_l = 2; dir_res = 0;
    for (int k = 0; k < 5; k++) begin
      set_req(k % N, 32'h0000_6000 + 32'(k), 1'(k));
      step();
      req_valid = '0;
      wait_rsp(30, n, ok);
      if (ok) begin
        cmp("sat_count", 64'(viol_count_s), 64'(exp_sat[k]));
        cmp("wide_count", 64'(viol_count), 64'(k + 1));
      end
    end

    // Randomized traffic
    rand_mode = 1;
    repeat (2500) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 35);
        req_addr[i*AW +: AW] = $urandom;
        req_we[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    rand_mode = 0;
    req_valid = '0;
    repeat (80) step();
    cmp("issue_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
